// File: rtl/est_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : est_pkg
//  Description : Shared definitions for the display-state sequencer and the
//                7-segment display FSM. Holds the state width, the four state
//                codes, the default debounce length and a helper that steps
//                a state one position forward or backward, modulo 4.
//  Revision    : 1.0 - initial release
// ============================================================================
package est_pkg;

    localparam int EST_W = 2;

    localparam logic [EST_W-1:0] EST_0 = 2'd0;
    localparam logic [EST_W-1:0] EST_1 = 2'd1;
    localparam logic [EST_W-1:0] EST_2 = 2'd2;
    localparam logic [EST_W-1:0] EST_3 = 2'd3;

    // 10 ms at 50 MHz
    localparam int DEB_CYCLES_DEF = 500000;

    // One step around the ring EST_0 -> EST_1 -> EST_2 -> EST_3 -> EST_0.
    // fwd=1 steps forward, fwd=0 steps backward.
    function automatic logic [EST_W-1:0] est_step(input logic [EST_W-1:0] cur,
                                                  input logic             fwd);
        logic [EST_W-1:0] nxt;
        unique case (cur)
            EST_0:   nxt = fwd ? EST_1 : EST_3;
            EST_1:   nxt = fwd ? EST_2 : EST_0;
            EST_2:   nxt = fwd ? EST_3 : EST_1;
            default: nxt = fwd ? EST_0 : EST_2;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Push-button conditioner. A 2-flop synchroniser feeds a
//                debounce counter; the debounced level only follows the
//                synchronised input after DEB_CYCLES consecutive cycles of
//                disagreement. A one-cycle press strobe marks each accepted
//                0->1 transition.
//  Ports       : clk     in  system clock
//                rest    in  asynchronous reset, active-low
//                btn_raw in  raw button, active-high, asynchronous to clk
//                press   out high in the cycle whose closing edge raises the
//                            debounced level
//  Parameters  : DEB_CYCLES  stable cycles needed to accept a level (>= 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rest,
    input  logic btn_raw,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             lvl_q;
    logic             lvl_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differ;
    logic             expire;

    assign differ = sync2_q ^ lvl_q;
    // Counter would reach DEB_CYCLES on this edge: accept the new level now.
    assign expire = differ && (cnt_q == CNT_LAST);
    // Combinational so the top level can step est on the same edge that
    // toggles the debounced level.
    assign press  = expire && !lvl_q;

    always_comb begin
        lvl_d = lvl_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (!differ) begin
            cnt_d = '0;
        end else if (expire) begin
            cnt_d = '0;
            lvl_d = ~lvl_q;
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/est_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : est_sequencer
//  Description : Mode selector for the 7-segment display FSM. Debounces two
//                push-buttons and steps the 2-bit display state est forward
//                (btn_next) or backward (btn_prev), modulo 4, with a
//                one-cycle est_chg strobe whenever est takes a new value.
//  Ports       : clk      in  system clock
//                rest     in  asynchronous reset, active-low
//                btn_next in  raw button: step est forward
//                btn_prev in  raw button: step est backward
//                est      out registered display state 0..3
//                est_chg  out high for the one cycle est shows a new value
//  Parameters  : DEB_CYCLES   debounce length in cycles (>= 2)
//                AUTO_CYCLES  auto-advance period (AUTO_ADVANCE_EN only)
//  Build macro : AUTO_ADVANCE_EN - when defined, est also advances by one
//                every AUTO_CYCLES cycles without button activity.
//  Revision    : 1.0 - initial release
// ============================================================================
module est_sequencer
    import est_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int AUTO_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             rest,
    input  logic             btn_next,
    input  logic             btn_prev,
    output logic [EST_W-1:0] est,
    output logic             est_chg
);

    logic             next_press;
    logic             prev_press;
    logic             any_press;
    logic             auto_tick;
    logic [EST_W-1:0] est_q;
    logic [EST_W-1:0] est_d;
    logic             est_chg_q;
    logic             est_chg_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
        .clk     (clk),
        .rest    (rest),
        .btn_raw (btn_next),
        .press   (next_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
        .clk     (clk),
        .rest    (rest),
        .btn_raw (btn_prev),
        .press   (prev_press)
    );

    // Simultaneous presses still count as activity: they cancel each other
    // but also swallow and restart any pending auto tick.
    assign any_press = next_press || prev_press;

`ifdef AUTO_ADVANCE_EN
    localparam int                AUTO_W    = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);

    logic [AUTO_W-1:0] auto_q;
    logic [AUTO_W-1:0] auto_d;

    assign auto_tick = (auto_q == AUTO_LAST);

    always_comb begin
        auto_d = auto_q + AUTO_W'(1);
        if (any_press || auto_tick) begin
            auto_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            auto_q <= '0;
        end else begin
            auto_q <= auto_d;
        end
    end
`else
    assign auto_tick = 1'b0;

    // AUTO_CYCLES has no effect in this build.
    if (AUTO_CYCLES < 0) begin : g_auto_unused
    end
`endif

    always_comb begin
        est_d = est_q;
        if (next_press != prev_press) begin
            est_d = est_step(est_q, next_press);
        end else if (!any_press && auto_tick) begin
            est_d = est_step(est_q, 1'b1);
        end
        est_chg_d = (est_d != est_q);
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            est_q     <= EST_0;
            est_chg_q <= 1'b0;
        end else begin
            est_q     <= est_d;
            est_chg_q <= est_chg_d;
        end
    end

    assign est     = est_q;
    assign est_chg = est_chg_q;

endmodule
`default_nettype wire

// File: tb/tb_est_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_est_sequencer
//  Description : Self-checking bench for est_sequencer (DEB_CYCLES=4,
//                AUTO_CYCLES=16). A reference model predicts every est step
//                from the raw button samples; a monitor compares each est_chg
//                strobe against the predicted queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_est_sequencer;

    localparam int DEB  = 4;
    localparam int AUTO = 16;
    localparam int HMAX = 16384;

    logic       clk      = 1'b0;
    logic       rest     = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic [1:0] est;
    logic       est_chg;

    est_sequencer #(
        .DEB_CYCLES  (DEB),
        .AUTO_CYCLES (AUTO)
    ) dut (
        .clk      (clk),
        .rest     (rest),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .est      (est),
        .est_chg  (est_chg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int edge_n;
        int est_v;
    } exp_t;

    exp_t sb[$];

    // ---------------- reference model ----------------
    // A level is accepted at edge e when the raw samples taken at edges
    // e-DEB-1 .. e-2 all disagree with the currently accepted level
    // (two edges of synchroniser delay, DEB samples of stability).
    int m_e;
    int m_est;
    int m_since;
    bit m_lvl_n;
    bit m_lvl_p;
    bit hn[HMAX];
    bit hp[HMAX];

    function automatic bit settled(input bit is_next, input bit lvl);
        if (m_e < DEB + 2) return 1'b0;
        for (int i = m_e - DEB - 1; i <= m_e - 2; i++) begin
            if ((is_next ? hn[i] : hp[i]) == lvl) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rest) begin : model
        bit tn, tp, pn, pp;
        int nest;
        if (!rest) begin
            m_e     = 0;
            m_est   = 0;
            m_since = 0;
            m_lvl_n = 1'b0;
            m_lvl_p = 1'b0;
        end else begin
            m_e = m_e + 1;
            hn[m_e % HMAX] = btn_next;
            hp[m_e % HMAX] = btn_prev;
            tn = settled(1'b1, m_lvl_n);
            tp = settled(1'b0, m_lvl_p);
            pn = tn && !m_lvl_n;
            pp = tp && !m_lvl_p;
            if (tn) m_lvl_n = !m_lvl_n;
            if (tp) m_lvl_p = !m_lvl_p;
            nest = m_est;
            if (pn != pp) nest = pn ? (m_est + 1) % 4 : (m_est + 3) % 4;
`ifdef AUTO_ADVANCE_EN
            m_since = m_since + 1;
            if (pn || pp) begin
                m_since = 0;
            end else if (m_since == AUTO) begin
                m_since = 0;
                nest = (m_est + 1) % 4;
            end
`endif
            if (nest != m_est) sb.push_back('{m_e, nest});
            m_est = nest;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t x;
        if (rest) begin
            while (sb.size() > 0 && sb[0].edge_n < m_e) begin
                checks++;
                $display("FAIL missed_step: no est_chg seen, required est=%0d after edge %0d", sb[0].est_v, sb[0].edge_n);
                void'(sb.pop_front());
            end
            if (est_chg) begin
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL spurious_chg: est_chg=1 est=%0d after edge %0d, required est_chg=0", est, m_e);
                end else begin
                    x = sb.pop_front();
                    if (x.edge_n == m_e && x.est_v == int'(est)) passes++;
                    else $display("FAIL step: est=%0d after edge %0d, required est=%0d after edge %0d", est, m_e, x.est_v, x.edge_n);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit nx, input bit pv, input int hold, input int gap);
        @(negedge clk);
        btn_next = nx;
        btn_prev = pv;
        idle(hold);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        idle(gap);
    endtask

    // Reset asserted between clock edges and checked before any edge arrives.
    task automatic mid_reset(input bit hold_next);
        @(posedge clk);
        #3;
        chk("sb_drained", sb.size(), 0);
        rest     = 1'b0;
        btn_next = hold_next;
        btn_prev = 1'b0;
        #1;
        chk("rst_est", int'(est), 0);
        chk("rst_chg", int'(est_chg), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        #2 rest = 1'b1;
    endtask

    initial begin : stim
        int rn, rp;
        #1;
        chk("init_est", int'(est), 0);
        chk("init_chg", int'(est_chg), 0);
        repeat (2) @(negedge clk);
        #2 rest = 1'b1;

        // four forward steps with wrap, then one backward wrap
        repeat (4) press(1'b1, 1'b0, 8, 8);
        press(1'b0, 1'b1, 8, 8);
        press(1'b1, 1'b0, 8, 8);

        // long hold: exactly one step
        press(1'b1, 1'b0, 20, 10);

        // bounce: 3-cycle pulses never qualify
        repeat (6) press(1'b1, 1'b0, 3, 3);
        idle(8);

        // both buttons together cancel
        press(1'b1, 1'b1, 10, 10);

        press(1'b1, 1'b0, 8, 10);
        chk("pre_reset_est", int'(est), m_est);

        // reset with btn_next already held: must debounce afresh afterwards
        mid_reset(1'b1);
        idle(12);
        btn_next = 1'b0;
        idle(10);

        // randomized button activity with bounces and overlaps
        rn = 1;
        rp = 1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rn--;
            rp--;
            if (rn == 0) begin
                btn_next = 1'($urandom_range(0, 1));
                rn = $urandom_range(1, 9);
            end
            if (rp == 0) begin
                btn_prev = 1'($urandom_range(0, 1));
                rp = $urandom_range(1, 9);
            end
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        idle(12);

`ifdef AUTO_ADVANCE_EN
        // press landing exactly on the first auto tick after reset
        mid_reset(1'b0);
        for (int w = 0; w < 50 && m_e < 10; w++) @(negedge clk);
        btn_next = 1'b1;
        idle(10);
        btn_next = 1'b0;
        idle(60);
`endif

        idle(12);
        chk("sb_empty_end", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
